// File: rtl/spi_reg_bank_pkg.sv
// Shared constants and types for the SPI register bank.
package spi_reg_pkg;

  localparam int FRAME_BITS = 16;
  localparam int CNT_W      = 5;

  // The bit counter stops one past a full frame so long frames stay "wrong length".
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY      = 7'h04;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/spi_reg_bank_if.sv
// SPI pins plus the PWM-facing control registers and status pulses.
interface spi_reg_bank_if;

  logic       sclk;
  logic       copi;
  logic       ncs;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       wr_strobe;
  logic       frame_err;

  modport slave (
    input  sclk, copi, ncs,
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
    output pwm_duty_cycle, wr_strobe, frame_err
  );

  modport master (
    output sclk, copi, ncs,
    input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
    input  pwm_duty_cycle, wr_strobe, frame_err
  );

endinterface

// File: rtl/spi_reg_bank_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, plus a history flop for edge detect.
module sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;

  // Shift the pin through the synchroniser chain and remember the previous level.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
      r_hist <= RST_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_hist;
  assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_hist;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI-slave write-only register bank feeding the PWM peripheral controls.
//
//   state     | meaning
//   ST_IDLE   | waiting for ncs to fall; other pin edges ignored
//   ST_SHIFT  | capturing copi on each sclk rise until ncs rises
//   ST_COMMIT | one cycle: apply a valid write, then idle or start next frame
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [6:0] MAX_ADDR    = 7'h04
) (
  input  logic           clk,
  input  logic           rst,
  spi_reg_bank_if.slave  bus
);

  logic w_sclk_level, w_sclk_rise, w_sclk_fall;
  logic w_copi_level, w_copi_rise, w_copi_fall;
  logic w_ncs_level,  w_ncs_rise,  w_ncs_fall;
  logic w_unused_edges;

  // ncs resets to "asserted" so a frame already running at reset release is skipped.
  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .i_clk(clk), .i_rst(rst), .i_pin(bus.sclk),
    .o_level(w_sclk_level), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
    .i_clk(clk), .i_rst(rst), .i_pin(bus.copi),
    .o_level(w_copi_level), .o_rise(w_copi_rise), .o_fall(w_copi_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_ncs (
    .i_clk(clk), .i_rst(rst), .i_pin(bus.ncs),
    .o_level(w_ncs_level), .o_rise(w_ncs_rise), .o_fall(w_ncs_fall)
  );

  assign w_unused_edges = ^{w_sclk_level, w_sclk_fall, w_copi_rise, w_copi_fall, w_ncs_level};

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [FRAME_BITS-1:0] r_shift;
  logic                  r_err_pend;
  logic                  r_wr_strobe;
  logic                  r_frame_err;
  logic [7:0]            r_en_out_lo, r_en_out_hi, r_en_pwm_lo, r_en_pwm_hi, r_duty;

  logic       w_rw;
  logic [6:0] w_addr;
  logic [7:0] w_data;

  assign w_rw   = r_shift[15];
  assign w_addr = r_shift[14:8];
  assign w_data = r_shift[7:0];

  // Frame FSM, bit counter, shift register and register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_err_pend  <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_frame_err <= 1'b0;
      r_en_out_lo <= '0;
      r_en_out_hi <= '0;
      r_en_pwm_lo <= '0;
      r_en_pwm_hi <= '0;
      r_duty      <= '0;
    end else begin
      r_wr_strobe <= 1'b0;
      // Delay the length error by a cycle so it lines up with the commit timing.
      r_frame_err <= r_err_pend;
      r_err_pend  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_ncs_fall) begin
            r_cnt   <= '0;
            r_shift <= '0;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // An ncs edge in the same cycle as an sclk rise takes priority.
          if (w_ncs_rise) begin
            if (r_cnt == CNT_FULL) begin
              r_state <= ST_COMMIT;
            end else begin
              r_err_pend <= 1'b1;
              r_state    <= ST_IDLE;
            end
          end else if (w_sclk_rise) begin
            r_shift <= {r_shift[FRAME_BITS-2:0], w_copi_level};
            if (r_cnt != CNT_SAT) begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_COMMIT: begin
          if (w_rw && (w_addr <= MAX_ADDR)) begin
            r_wr_strobe <= 1'b1;
            case (w_addr)
              ADDR_EN_OUT_LO: r_en_out_lo <= w_data;
              ADDR_EN_OUT_HI: r_en_out_hi <= w_data;
              ADDR_EN_PWM_LO: r_en_pwm_lo <= w_data;
              ADDR_EN_PWM_HI: r_en_pwm_hi <= w_data;
              ADDR_DUTY:      r_duty      <= w_data;
              default:        ;
            endcase
          end
          if (w_ncs_fall) begin
            r_cnt   <= '0;
            r_shift <= '0;
            r_state <= ST_SHIFT;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.en_reg_out_7_0  = r_en_out_lo;
  assign bus.en_reg_out_15_8 = r_en_out_hi;
  assign bus.en_reg_pwm_7_0  = r_en_pwm_lo;
  assign bus.en_reg_pwm_15_8 = r_en_pwm_hi;
  assign bus.pwm_duty_cycle  = r_duty;
  assign bus.wr_strobe       = r_wr_strobe;
  assign bus.frame_err       = r_frame_err;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank with a write scoreboard.
module tb_spi_reg_bank;

  logic clk = 1'b0;
  logic rst = 1'b1;

  spi_reg_bank_if u_if ();

  spi_reg_bank #(.SYNC_STAGES(2), .MAX_ADDR(7'h04)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  logic [7:0]  exp_regs [5];
  logic [15:0] sb_q [$];
  int exp_wr = 0, exp_err = 0;
  int wr_seen = 0, err_seen = 0;
  logic prev_wr = 1'b0, prev_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] reg_at(input logic [7:0] a);
    case (a)
      8'd0:    return u_if.en_reg_out_7_0;
      8'd1:    return u_if.en_reg_out_15_8;
      8'd2:    return u_if.en_reg_pwm_7_0;
      8'd3:    return u_if.en_reg_pwm_15_8;
      8'd4:    return u_if.pwm_duty_cycle;
      default: return 8'hxx;
    endcase
  endfunction

  // Scoreboard monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (u_if.wr_strobe) begin
      wr_seen++;
      check("wr_strobe_width", {31'd0, prev_wr}, 32'd0);
      if (sb_q.size() == 0) begin
        check("unexpected_wr_strobe", 32'd1, 32'd0);
      end else begin
        logic [15:0] e;
        e = sb_q.pop_front();
        check("sb_reg_value", {24'd0, reg_at(e[15:8])}, {24'd0, e[7:0]});
      end
    end
    if (u_if.frame_err) begin
      err_seen++;
      check("frame_err_width", {31'd0, prev_err}, 32'd0);
    end
    prev_wr  = u_if.wr_strobe;
    prev_err = u_if.frame_err;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame_begin();
    u_if.ncs = 1'b0;
    tick(4);
  endtask

  task automatic send_bit(input logic b);
    u_if.copi = b;
    tick(2);
    u_if.sclk = 1'b1;
    tick(4);
    u_if.sclk = 1'b0;
    tick(2);
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic frame_end();
    u_if.ncs = 1'b1;
  endtask

  // Model a committed 16-bit frame.
  task automatic expect_frame(input logic [15:0] f);
    if (f[15] && (f[14:8] <= 7'h04)) begin
      exp_regs[f[10:8]] = f[7:0];
      sb_q.push_back({1'b0, f[14:8], f[7:0]});
      exp_wr++;
    end
  endtask

  task automatic full_frame(input logic [15:0] f, input int gap);
    expect_frame(f);
    frame_begin();
    send_bits({16'd0, f}, 16);
    frame_end();
    tick(gap);
  endtask

  task automatic check_all(input string tag);
    check({tag, ":en_out_lo"}, {24'd0, u_if.en_reg_out_7_0},  {24'd0, exp_regs[0]});
    check({tag, ":en_out_hi"}, {24'd0, u_if.en_reg_out_15_8}, {24'd0, exp_regs[1]});
    check({tag, ":en_pwm_lo"}, {24'd0, u_if.en_reg_pwm_7_0},  {24'd0, exp_regs[2]});
    check({tag, ":en_pwm_hi"}, {24'd0, u_if.en_reg_pwm_15_8}, {24'd0, exp_regs[3]});
    check({tag, ":duty"},      {24'd0, u_if.pwm_duty_cycle},  {24'd0, exp_regs[4]});
    check({tag, ":wr_count"},  wr_seen,  exp_wr);
    check({tag, ":err_count"}, err_seen, exp_err);
  endtask

  initial begin
    for (int i = 0; i < 5; i++) exp_regs[i] = 8'h00;
    u_if.sclk = 1'b0;
    u_if.copi = 1'b0;
    u_if.ncs  = 1'b1;
    tick(3);
    rst = 1'b0;
    check("reset_strobe", {31'd0, u_if.wr_strobe}, 32'd0);
    check("reset_err",    {31'd0, u_if.frame_err}, 32'd0);
    check_all("reset");
    tick(6);

    // Write 0xAB to address 0 and check commit lands on edge 4 after ncs rises.
    expect_frame(16'h80AB);
    frame_begin();
    send_bits(32'h80AB, 16);
    frame_end();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("edge3_strobe", {31'd0, u_if.wr_strobe}, 32'd0);
    check("edge3_reg",    {24'd0, u_if.en_reg_out_7_0}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("edge4_strobe", {31'd0, u_if.wr_strobe}, 32'd1);
    check("edge4_reg",    {24'd0, u_if.en_reg_out_7_0}, 32'hAB);
    tick(8);
    check_all("write_80AB");

    // Back-to-back frames with one clk of ncs high between them.
    full_frame(16'h8480, 1);
    full_frame(16'h83F0, 10);
    check_all("back_to_back");

    // Read frame and out-of-range address: no effect.
    full_frame(16'h0055, 2);
    full_frame(16'h8512, 10);
    check_all("ignored_frames");

    // 15-bit and 18-bit frames both report a length error.
    frame_begin();
    send_bits(32'h4066, 15);
    frame_end();
    exp_err++;
    tick(10);
    check_all("short_frame");
    frame_begin();
    send_bits({14'd0, 16'h80FF, 2'b11}, 18);
    frame_end();
    exp_err++;
    tick(10);
    check_all("long_frame");
    full_frame(16'h8011, 10);
    check_all("after_bad_len");

    // Fill all registers with 0xFF, then reset in the middle of a frame.
    for (int a = 0; a < 5; a++) full_frame({1'b1, 7'(a), 8'hFF}, 2);
    tick(8);
    check_all("all_ff");
    frame_begin();
    send_bits(32'h82, 8);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) exp_regs[i] = 8'h00;
    check("midreset_strobe", {31'd0, u_if.wr_strobe}, 32'd0);
    check_all("mid_reset");
    send_bits(32'h77, 8);
    frame_end();
    tick(12);
    check_all("after_reset_tail");
    full_frame(16'h8133, 10);
    check_all("post_reset_frame");

    // 17th sclk rise lands together with ncs rising: still a 16-bit frame.
    expect_frame(16'h8266);
    frame_begin();
    send_bits(32'h8266, 16);
    u_if.copi = 1'b1;
    tick(2);
    u_if.sclk = 1'b1;
    u_if.ncs  = 1'b1;
    tick(4);
    u_if.sclk = 1'b0;
    tick(10);
    check_all("coincident_edge");

    check("sb_queue_empty", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
